// File: rtl/rx_phase_sched.sv
// rtl/rx_phase_sched.sv - strobe-aligned NCO phase-word update scheduler
// Queues host phase writes and applies them to per-channel registers on sample boundaries.
module rx_phase_sched #(
   parameter int NRX   = 4,
   parameter int DEPTH = 4,
   // One spare bit so out-of-range targets can be written and flagged.
   localparam int RXW  = $clog2(NRX) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 wr_valid_i,
   output logic                 wr_ready_o,
   input  logic [RXW-1:0]       wr_rx_i,
   input  logic [31:0]          wr_phi_i,
   input  logic                 sample_stb_i,
   input  logic                 hold_i,
   output logic [32*NRX-1:0]    phi_o,
   output logic [NRX-1:0]       upd_o,
   output logic                 pending_o,
   output logic                 err_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic {IDLE, ARM} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [32*NRX-1:0]   phi_q, phi_d;
   logic [NRX-1:0]      upd_q, upd_d;
   logic                err_q, err_d;
   logic                rdy_q, rdy_d;

   logic [RXW-1:0]      rx_mem  [DEPTH];
   logic [31:0]         phi_mem [DEPTH];

   logic                push, apply, pair, h_ok;
   logic [1:0]          pop_n;
   logic [RXW-1:0]      h_rx, s_rx;
   logic [31:0]         h_phi, s_phi;

   always_comb begin
      state_d  = state_q;
      h_rx     = rx_mem[rd_ptr_q];
      h_phi    = phi_mem[rd_ptr_q];
      s_rx     = rx_mem[rd_ptr_q + AW'(1)];
      s_phi    = phi_mem[rd_ptr_q + AW'(1)];
      push     = wr_valid_i && rdy_q;
      h_ok     = h_rx < RXW'(NRX);
      pair     = (count_q >= CW'(2)) && h_ok && (s_rx == (h_rx ^ RXW'(1)));
      apply    = (state_q == ARM) && sample_stb_i && !hold_i;
      pop_n    = apply ? (pair ? 2'd2 : 2'd1) : 2'd0;
      count_d  = count_q + CW'(push) - CW'(pop_n);
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rdy_d    = count_d != CW'(DEPTH);
      phi_d    = phi_q;
      upd_d    = '0;
      err_d    = err_q | (apply && !h_ok);

      case (state_q)
         IDLE:    if (push) state_d = ARM;
         ARM:     if (count_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Head and its pair partner are distinct channels, so both writes can land together.
      for (int n = 0; n < NRX; n++) begin
         if (apply && h_rx == RXW'(n)) begin
            phi_d[32*n +: 32] = h_phi;
            upd_d[n]          = 1'b1;
         end
         if (apply && pair && s_rx == RXW'(n)) begin
            phi_d[32*n +: 32] = s_phi;
            upd_d[n]          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         phi_q    <= '0;
         upd_q    <= '0;
         err_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         phi_q    <= phi_d;
         upd_q    <= upd_d;
         err_q    <= err_d;
         rdy_q    <= rdy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         rx_mem[wr_ptr_q]  <= wr_rx_i;
         phi_mem[wr_ptr_q] <= wr_phi_i;
      end
   end

   assign wr_ready_o = rdy_q;
   assign phi_o      = phi_q;
   assign upd_o      = upd_q;
   assign pending_o  = count_q != '0;
   assign err_o      = err_q;
endmodule

// File: tb/tb_rx_phase_sched.sv
// tb/tb_rx_phase_sched.sv - directed bench for rx_phase_sched
// Four channels, depth-4 FIFO; expected phase vector kept locally.
module tb_rx_phase_sched;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wr_valid = 1'b0;
   logic         wr_ready;
   logic [2:0]   wr_rx = '0;
   logic [31:0]  wr_phi = '0;
   logic         sample_stb = 1'b0;
   logic         hold = 1'b0;
   logic [127:0] phi;
   logic [3:0]   upd;
   logic         pending;
   logic         err;

   logic [127:0] exp_phi = '0;
   int           vec = 0;
   int           miss = 0;

   rx_phase_sched #(.NRX(4), .DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .wr_rx_i(wr_rx), .wr_phi_i(wr_phi), .sample_stb_i(sample_stb), .hold_i(hold),
      .phi_o(phi), .upd_o(upd), .pending_o(pending), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] rx, input logic [31:0] v);
      wr_rx = rx; wr_phi = v; wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic strobe();
      sample_stb = 1'b1;
      step();
      sample_stb = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      vec++; if (phi !== 128'h0) begin miss++; $display("FAIL rst_phi got %h want 0", phi); end
      vec++; if ({upd, err, pending, wr_ready} !== 7'b0) begin miss++; $display("FAIL rst_flags got %b want 0", {upd, err, pending, wr_ready}); end
      @(negedge clk); rst_n = 1'b1; #1;
      vec++; if (wr_ready !== 1'b0) begin miss++; $display("FAIL rdy_before_edge got %b want 0", wr_ready); end
      step();
      vec++; if (wr_ready !== 1'b1) begin miss++; $display("FAIL rdy_after_edge got %b want 1", wr_ready); end
   endtask

   task automatic test_single();
      push(3'd1, 32'h1000_0000);
      for (int i = 0; i < 10; i++) step();
      vec++; if (phi !== exp_phi || pending !== 1'b1) begin miss++; $display("FAIL single_wait phi %h pend %b want %h 1", phi, pending, exp_phi); end
      strobe();
      exp_phi[32 +: 32] = 32'h1000_0000;
      vec++; if (phi !== exp_phi) begin miss++; $display("FAIL single_phi got %h want %h", phi, exp_phi); end
      vec++; if (upd !== 4'b0010 || pending !== 1'b0) begin miss++; $display("FAIL single_upd upd %b pend %b want 0010 0", upd, pending); end
      step();
      vec++; if (upd !== 4'b0000) begin miss++; $display("FAIL single_upd_clear got %b want 0000", upd); end
   endtask

   task automatic test_stb_on_push();
      wr_rx = 3'd3; wr_phi = 32'h3333_0001; wr_valid = 1'b1; sample_stb = 1'b1;
      step();
      wr_valid = 1'b0; sample_stb = 1'b0;
      vec++; if (phi !== exp_phi || upd !== 4'b0 || pending !== 1'b1) begin miss++; $display("FAIL stb_on_push phi %h upd %b pend %b", phi, upd, pending); end
      strobe();
      exp_phi[96 +: 32] = 32'h3333_0001;
      vec++; if (phi !== exp_phi || upd !== 4'b1000) begin miss++; $display("FAIL stb_after_push phi %h upd %b want %h 1000", phi, upd, exp_phi); end
   endtask

   task automatic test_pair();
      push(3'd2, 32'h2222_2222);
      push(3'd3, 32'h3333_3333);
      strobe();
      exp_phi[64 +: 32] = 32'h2222_2222;
      exp_phi[96 +: 32] = 32'h3333_3333;
      vec++; if (phi !== exp_phi) begin miss++; $display("FAIL pair_phi got %h want %h", phi, exp_phi); end
      vec++; if (upd !== 4'b1100 || pending !== 1'b0) begin miss++; $display("FAIL pair_upd upd %b pend %b want 1100 0", upd, pending); end
   endtask

   task automatic test_same_channel();
      push(3'd0, 32'h0000_000A);
      push(3'd0, 32'h0000_000B);
      strobe();
      exp_phi[0 +: 32] = 32'h0000_000A;
      vec++; if (phi !== exp_phi || upd !== 4'b0001 || pending !== 1'b1) begin miss++; $display("FAIL same_first phi %h upd %b pend %b", phi, upd, pending); end
      step();
      vec++; if (upd !== 4'b0000) begin miss++; $display("FAIL same_gap got %b want 0000", upd); end
      strobe();
      exp_phi[0 +: 32] = 32'h0000_000B;
      vec++; if (phi !== exp_phi || upd !== 4'b0001 || pending !== 1'b0) begin miss++; $display("FAIL same_second phi %h upd %b pend %b", phi, upd, pending); end
   endtask

   task automatic test_full_back_to_back();
      for (int i = 1; i <= 4; i++) push(3'd0, 32'(i));
      vec++; if (wr_ready !== 1'b0) begin miss++; $display("FAIL full_rdy got %b want 0", wr_ready); end
      wr_rx = 3'd1; wr_phi = 32'hDEAD_BEEF; wr_valid = 1'b1;
      step();
      vec++; if (wr_ready !== 1'b0 || phi !== exp_phi) begin miss++; $display("FAIL full_hold rdy %b phi %h", wr_ready, phi); end
      sample_stb = 1'b1;
      step();
      wr_valid = 1'b0;
      exp_phi[0 +: 32] = 32'd1;
      vec++; if (phi !== exp_phi || upd !== 4'b0001 || wr_ready !== 1'b1) begin miss++; $display("FAIL full_pop phi %h upd %b rdy %b", phi, upd, wr_ready); end
      for (int i = 2; i <= 4; i++) begin
         step();
         exp_phi[0 +: 32] = 32'(i);
         vec++; if (phi !== exp_phi || upd !== 4'b0001) begin miss++; $display("FAIL b2b_%0d phi %h upd %b want %h 0001", i, phi, upd, exp_phi); end
      end
      sample_stb = 1'b0;
      vec++; if (pending !== 1'b0) begin miss++; $display("FAIL refused_push pend got %b want 0", pending); end
   endtask

   task automatic test_hold();
      push(3'd1, 32'h5555_5555);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin strobe(); step(); end
      vec++; if (phi !== exp_phi || upd !== 4'b0 || pending !== 1'b1) begin miss++; $display("FAIL hold phi %h upd %b pend %b", phi, upd, pending); end
      hold = 1'b0;
      step();
      strobe();
      exp_phi[32 +: 32] = 32'h5555_5555;
      vec++; if (phi !== exp_phi || upd !== 4'b0010) begin miss++; $display("FAIL hold_release phi %h upd %b", phi, upd); end
   endtask

   task automatic test_err();
      vec++; if (err !== 1'b0) begin miss++; $display("FAIL err_pre got %b want 0", err); end
      push(3'd5, 32'h7777_7777);
      strobe();
      vec++; if (err !== 1'b1 || upd !== 4'b0 || phi !== exp_phi || pending !== 1'b0) begin miss++; $display("FAIL err_apply err %b upd %b pend %b phi %h", err, upd, pending, phi); end
      step(); step();
      vec++; if (err !== 1'b1) begin miss++; $display("FAIL err_sticky got %b want 1", err); end
   endtask

   task automatic test_reset_mid();
      push(3'd0, 32'h1);
      push(3'd2, 32'h2);
      push(3'd1, 32'h3);
      vec++; if (pending !== 1'b1) begin miss++; $display("FAIL mid_pend_pre got %b want 1", pending); end
      #2 rst_n = 1'b0;
      #1;
      exp_phi = '0;
      vec++; if (phi !== exp_phi || err !== 1'b0 || pending !== 1'b0 || wr_ready !== 1'b0) begin miss++; $display("FAIL mid_reset phi %h err %b pend %b rdy %b", phi, err, pending, wr_ready); end
      @(negedge clk); rst_n = 1'b1;
      step();
      strobe();
      vec++; if (phi !== exp_phi || upd !== 4'b0 || wr_ready !== 1'b1) begin miss++; $display("FAIL post_reset phi %h upd %b rdy %b", phi, upd, wr_ready); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stb_on_push();
      test_pair();
      test_same_channel();
      test_full_back_to_back();
      test_hold();
      test_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
